// File: rtl/v_tile_pkg.sv
// Shared types and constants for the tile result sender.
package v_tile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_SEND     = 2'd2
  } state_t;

  localparam logic [1:0] DEST_N = 2'd0;
  localparam logic [1:0] DEST_E = 2'd1;
  localparam logic [1:0] DEST_S = 2'd2;
  localparam logic [1:0] DEST_W = 2'd3;

  // Service order is N, E, S, W; callers only pass non-zero masks.
  function automatic logic [1:0] lowest_bit(input logic [3:0] mask);
    if (mask[DEST_N])      return DEST_N;
    else if (mask[DEST_E]) return DEST_E;
    else if (mask[DEST_S]) return DEST_S;
    else                   return DEST_W;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO buffering {result, dest mask} entries ahead of the sender FSM.
module result_fifo #(
  parameter int width = 68,
  parameter int depth = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [width-1:0] i_data,
  output logic [width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [width-1:0] r_mem [depth];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees the head slot this cycle, so a push while full still fits.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/v_tile_sender.sv
// Forwards adder results to up to four neighbours, one destination at a time.
//   state    | meaning
//   IDLE     | no transfer in flight; pops the FIFO head when one is available
//   WAIT_RDY | holding a result for port r_cur until that neighbour is ready
//   SEND     | write_en[r_cur] high with data stable until write_ack[r_cur]
module v_tile_sender
  import v_tile_pkg::*;
#(
  parameter int width      = 16,
  parameter int num_inputs = 4,
  parameter int fifo_depth = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [width*num_inputs-1:0] adder_outputs,
  input  logic [3:0]                  dest_info,
  input  logic                        adder_ack,
  output logic [3:0]                  write_en,
  input  logic [3:0]                  write_rdy,
  input  logic [3:0]                  write_ack,
  output logic [width*num_inputs-1:0] w_data_out,
  output logic                        busy,
  output logic                        overflow,
  output logic [7:0]                  drop_cnt
);

  localparam int DW = width * num_inputs;
  localparam int EW = DW + 4;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_data;
  logic [DW-1:0] w_data_nxt;
  logic [3:0]    r_mask;
  logic [3:0]    w_mask_nxt;
  logic [1:0]    r_cur;
  logic [1:0]    w_cur_nxt;
  logic [DW-1:0] r_data_out;
  logic          r_overflow;
  logic [7:0]    r_drop_cnt;

  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_drop_zero;
  logic          w_load_out;
  logic [EW-1:0] w_head;
  logic [3:0]    w_mask_left;

  result_fifo #(
    .width (EW),
    .depth (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (adder_ack),
    .i_pop   (w_pop),
    .i_data  ({adder_outputs, dest_info}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_mask_nxt  = r_mask;
    w_cur_nxt   = r_cur;
    w_pop       = 1'b0;
    w_drop_zero = 1'b0;
    w_load_out  = 1'b0;
    w_mask_left = r_mask & ~(4'b0001 << r_cur);
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_data_nxt = w_head[EW-1:4];
          w_mask_nxt = w_head[3:0];
          if (w_head[3:0] == 4'b0000) begin
            w_drop_zero = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT_RDY;
            w_cur_nxt   = lowest_bit(w_head[3:0]);
          end
        end
      end
      ST_WAIT_RDY: begin
        if (write_rdy[r_cur]) begin
          w_state_nxt = ST_SEND;
          w_load_out  = 1'b1;
        end
      end
      ST_SEND: begin
        // Acks on other ports are ignored by indexing with r_cur only.
        if (write_ack[r_cur]) begin
          w_mask_nxt = w_mask_left;
          if (w_mask_left != 4'b0000) begin
            w_state_nxt = ST_WAIT_RDY;
            w_cur_nxt   = lowest_bit(w_mask_left);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_data     <= '0;
      r_mask     <= '0;
      r_cur      <= '0;
      r_data_out <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_mask  <= w_mask_nxt;
      r_cur   <= w_cur_nxt;
      // Bus only reloads on entry to SEND so it holds its last value otherwise.
      if (w_load_out) r_data_out <= r_data;
      if (adder_ack && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_drop_zero && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign write_en   = (r_state == ST_SEND) ? (4'b0001 << r_cur) : 4'b0000;
  assign w_data_out = r_data_out;
  assign busy       = !w_empty || (r_state != ST_IDLE);
  assign overflow   = r_overflow;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_v_tile_sender.sv
// Self-checking bench for v_tile_sender: vector table plus scoreboard of expected writes.
module tb_v_tile_sender;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] adder_outputs;
  logic [3:0]  dest_info;
  logic        adder_ack;
  logic [3:0]  write_en;
  logic [3:0]  write_rdy;
  logic [3:0]  write_ack;
  logic [63:0] w_data_out;
  logic        busy;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  en;
    logic [63:0] data;
  } xfer_t;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  dest;
    int          ack_dly;
    logic [3:0]  stray;
    int          exp_sends;
    int          exp_drops;
  } vec_t;

  xfer_t      exp_q[$];
  xfer_t      cur_x;
  int         sends_seen = 0;
  int         ack_delay  = 0;
  logic       ack_enable = 1'b1;
  logic [3:0] stray_ack  = 4'b0000;

  v_tile_sender #(
    .width      (16),
    .num_inputs (4),
    .fifo_depth (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .adder_outputs (adder_outputs),
    .dest_info     (dest_info),
    .adder_ack     (adder_ack),
    .write_en      (write_en),
    .write_rdy     (write_rdy),
    .write_ack     (write_ack),
    .w_data_out    (w_data_out),
    .busy          (busy),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected writes for one result: one per set mask bit, N first.
  task automatic enqueue(input logic [63:0] d, input logic [3:0] m);
    xfer_t x;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        x.en   = 4'b0001 << i;
        x.data = d;
        exp_q.push_back(x);
      end
    end
  endtask

  task automatic push_one(input logic [63:0] d, input logic [3:0] m);
    adder_outputs = d;
    dest_info     = m;
    adder_ack     = 1'b1;
    @(negedge clk);
    adder_ack     = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int  n;
    logic done;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = (exp_q.size() == 0) && !busy && (write_en == 4'b0000);
    end
    check(name, {63'd0, done}, 64'd1);
  endtask

  // Neighbour model: acks the current port after ack_delay cycles, plus optional stray acks.
  initial begin
    int cnt;
    cnt       = 0;
    write_ack = 4'b0000;
    forever begin
      @(negedge clk);
      if (write_en == 4'b0000) begin
        cnt       = 0;
        write_ack = stray_ack;
      end else begin
        write_ack = ((ack_enable && cnt >= ack_delay) ? write_en : 4'b0000) | (stray_ack & ~write_en);
        cnt++;
      end
    end
  end

  // Scoreboard: each new write_en assertion consumes one expected transfer.
  initial begin
    logic [3:0] prev_en;
    prev_en  = 4'b0000;
    cur_x.en = 4'b0000;
    forever begin
      @(negedge clk);
      if (write_en != 4'b0000) begin
        if (prev_en == 4'b0000) begin
          sends_seen++;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got en=%b data=%h, expected no write", write_en, w_data_out);
            cur_x.en   = 4'b0000;
            cur_x.data = '0;
          end else begin
            cur_x = exp_q.pop_front();
          end
        end
        check("sb_write_en", {60'd0, write_en}, {60'd0, cur_x.en});
        check("sb_data", w_data_out, cur_x.data);
      end
      prev_en = write_en;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs[6];
    int    exp_drop;
    int    base;
    int    hi;
    logic [63:0] d;

    vecs[0] = '{64'h0011_0022_0033_0044, 4'b0001, 0, 4'b0000, 1, 0};
    vecs[1] = '{64'hA000_B000_C000_D000, 4'b1011, 1, 4'b0000, 3, 0};
    vecs[2] = '{64'h1234_5678_9ABC_DEF0, 4'b1111, 0, 4'b1111, 4, 0};
    vecs[3] = '{64'hDEAD_BEEF_0000_0001, 4'b0000, 0, 4'b0000, 0, 1};
    vecs[4] = '{64'hFFFF_0000_FFFF_0000, 4'b1000, 3, 4'b1111, 1, 0};
    vecs[5] = '{64'h0F0F_F0F0_5555_AAAA, 4'b0110, 2, 4'b0000, 2, 0};
    exp_drop = 0;

    reset         = 1'b0;
    adder_outputs = '0;
    dest_info     = 4'b0000;
    adder_ack     = 1'b0;
    write_rdy     = 4'b1111;
    #1;
    check("rst_write_en", {60'd0, write_en}, 64'd0);
    check("rst_data", w_data_out, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check("rst_drop_cnt", {56'd0, drop_cnt}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single result, minimum latency and a two-cycle write.
    ack_delay = 1;
    d = {16'd1, 16'd2, 16'd3, 16'd4};
    enqueue(d, 4'b0010);
    adder_outputs = d;
    dest_info     = 4'b0010;
    adder_ack     = 1'b1;
    @(posedge clk); #1 adder_ack = 1'b0;
    check("lat_t0_en", {60'd0, write_en}, 64'd0);
    check("lat_t0_busy", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    check("lat_t1_en", {60'd0, write_en}, 64'd0);
    @(posedge clk); #1;
    check("lat_t2_en", {60'd0, write_en}, 64'b0010);
    check("lat_t2_data", w_data_out, d);
    @(posedge clk); #1;
    check("lat_t3_en", {60'd0, write_en}, 64'b0010);
    @(posedge clk); #1;
    check("lat_t4_en", {60'd0, write_en}, 64'd0);
    check("lat_t4_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("hold_data_idle", w_data_out, d);

    for (int i = 0; i < 6; i++) begin
      ack_delay = vecs[i].ack_dly;
      stray_ack = vecs[i].stray;
      base      = sends_seen;
      enqueue(vecs[i].data, vecs[i].dest);
      push_one(vecs[i].data, vecs[i].dest);
      wait_idle($sformatf("vec%0d_idle", i), 100);
      exp_drop += vecs[i].exp_drops;
      check($sformatf("vec%0d_sends", i), 64'(sends_seen - base), 64'(vecs[i].exp_sends));
      check($sformatf("vec%0d_drop_cnt", i), {56'd0, drop_cnt}, 64'(exp_drop));
    end
    stray_ack = 4'b0000;
    ack_delay = 0;

    // Backpressure on S with stray acks that must be ignored.
    write_rdy = 4'b1011;
    stray_ack = 4'b1111;
    base = sends_seen;
    d = 64'hCAFE_0001_CAFE_0002;
    enqueue(d, 4'b0100);
    push_one(d, 4'b0100);
    hi = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (write_en != 4'b0000) hi++;
    end
    check("bp_no_write", 64'(hi), 64'd0);
    check("bp_busy", {63'd0, busy}, 64'd1);
    write_rdy = 4'b1111;
    stray_ack = 4'b0000;
    wait_idle("bp_idle", 50);
    check("bp_sends", 64'(sends_seen - base), 64'd1);

    // 300 zero-destination results back to back: counter saturates, no overflow.
    adder_outputs = 64'h0;
    dest_info     = 4'b0000;
    adder_ack     = 1'b1;
    repeat (300) @(negedge clk);
    adder_ack = 1'b0;
    wait_idle("zero_idle", 20);
    exp_drop += 300;
    check("zero_drop_sat", {56'd0, drop_cnt}, 64'(exp_drop > 255 ? 255 : exp_drop));
    check("zero_no_overflow", {63'd0, overflow}, 64'd0);

    // Four results with the sink stalled: only three fit, the fourth is dropped.
    ack_enable = 1'b0;
    base = sends_seen;
    for (int k = 1; k <= 3; k++) enqueue(64'(k), 4'b0001);
    for (int k = 1; k <= 4; k++) push_one(64'(k), 4'b0001);
    repeat (3) @(negedge clk);
    check("ovf_flag", {63'd0, overflow}, 64'd1);
    check("ovf_stall_en", {60'd0, write_en}, 64'b0001);
    ack_enable = 1'b1;
    wait_idle("ovf_idle", 50);
    check("ovf_sends", 64'(sends_seen - base), 64'd3);
    check("ovf_sticky", {63'd0, overflow}, 64'd1);

    // Reset while sending abandons the transfer and the buffered result.
    ack_enable = 1'b0;
    enqueue(64'h5151_5151_5151_5151, 4'b0001);
    push_one(64'h5151_5151_5151_5151, 4'b0001);
    push_one(64'h7272_7272_7272_7272, 4'b0010);
    hi = 0;
    for (int c = 0; c < 20 && write_en != 4'b0001; c++) @(negedge clk);
    check("rs_sending", {60'd0, write_en}, 64'b0001);
    #2 reset = 1'b0;
    #1;
    check("rs_write_en", {60'd0, write_en}, 64'd0);
    check("rs_busy", {63'd0, busy}, 64'd0);
    check("rs_data", w_data_out, 64'd0);
    check("rs_overflow", {63'd0, overflow}, 64'd0);
    check("rs_drop_cnt", {56'd0, drop_cnt}, 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset      = 1'b1;
    ack_enable = 1'b1;
    base = sends_seen;
    repeat (20) @(negedge clk);
    check("rs_no_resume", 64'(sends_seen - base), 64'd0);
    check("rs_idle_busy", {63'd0, busy}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
